// File: rtl/demux_rr_ctrl.sv
// Round-robin 1-to-4 serial bit demultiplexer with a per-channel valid/ready handshake.
// Optional macro DEMUX_TIMEOUT_EN skips a channel that stays not-ready for TIMEOUT cycles.
module demux_rr_ctrl #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       D,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] out_ready,
    output logic [1:0] S,
    output logic [3:0] Y,
    output logic [3:0] out_valid,
    output logic       skip
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t     state;
    logic       hold;
    logic [1:0] s_next;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("demux_rr_ctrl: TIMEOUT must lie in 2..255");
    end

    function automatic logic [3:0] onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

    function automatic logic [3:0] steer(input logic bit_in, input logic [1:0] sel);
        return bit_in ? onehot(sel) : 4'b0000;
    endfunction

    assign s_next   = S + 2'd1;
    assign in_ready = (state == IDLE);

`ifdef DEMUX_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       skip_r;

    assign skip = skip_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            S         <= 2'd0;
            hold      <= 1'b0;
            wait_cnt  <= 8'd0;
            Y         <= 4'b0000;
            out_valid <= 4'b0000;
            skip_r    <= 1'b0;
        end else begin
            skip_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold      <= D;
                        wait_cnt  <= 8'd0;
                        state     <= WAIT;
                        out_valid <= onehot(S);
                        Y         <= steer(D, S);
                    end
                end
                WAIT: begin
                    // A ready sink wins over a timeout reached in the same cycle.
                    if (out_ready[S]) begin
                        state     <= IDLE;
                        S         <= s_next;
                        wait_cnt  <= 8'd0;
                        out_valid <= 4'b0000;
                        Y         <= 4'b0000;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        S         <= s_next;
                        wait_cnt  <= 8'd0;
                        skip_r    <= 1'b1;
                        out_valid <= onehot(s_next);
                        Y         <= steer(hold, s_next);
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    // Strict round-robin: the selected channel is waited on indefinitely.
    assign skip = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            S         <= 2'd0;
            hold      <= 1'b0;
            Y         <= 4'b0000;
            out_valid <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold      <= D;
                        state     <= WAIT;
                        out_valid <= onehot(S);
                        Y         <= steer(D, S);
                    end
                end
                WAIT: begin
                    if (out_ready[S]) begin
                        state     <= IDLE;
                        S         <= s_next;
                        out_valid <= 4'b0000;
                        Y         <= 4'b0000;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: doc/demux_rr_ctrl.md
DEMUX_RR_CTRL -- requirements
Module: demux_rr_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8, meaning the consecutive not-ready cycles tolerated on one channel before it is skipped; legal range is 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port D, input, 1 bit: the serial data bit offered by the source.
REQ-005 The block SHALL have port in_valid, input, 1 bit: D is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts D this cycle.
REQ-007 The block SHALL have port out_ready, input, 4 bits: per-channel sink ready.
REQ-008 The block SHALL have port S, output, 2 bits: the currently selected channel (round-robin pointer).
REQ-009 The block SHALL have port Y, output, 4 bits: demultiplexed data; Y[S] carries the held bit and all other bits are 0.
REQ-010 The block SHALL have port out_valid, output, 4 bits: one-hot, or all-zero, channel-valid.
REQ-011 The block SHALL have port skip, output, 1 bit: a one-cycle pulse when a channel is skipped on timeout.

Function
REQ-012 The block SHALL implement a 2-state FSM with states IDLE and WAIT.
REQ-013 in_ready SHALL equal 1 exactly when the state is IDLE; it is a combinational decode of the state register.
REQ-014 In IDLE with in_valid=1, the block SHALL capture D into the hold register, clear the wait counter, and enter WAIT on the next edge.
REQ-015 In IDLE with in_valid=0, the block SHALL hold its state.
REQ-016 In WAIT, the outputs SHALL be registered: out_valid[S]=1 with all other bits 0, Y[S]=hold with all other bits 0.
REQ-017 In IDLE, out_valid and Y SHALL be all-zero.
REQ-018 In WAIT with out_ready[S]=1, the bit SHALL transfer that cycle; on the next edge S increments modulo 4 (3 wraps to 0) and the state returns to IDLE.
REQ-019 Sustained throughput SHALL be 1 bit per 2 cycles; latency from acceptance to out_valid SHALL be 1 cycle.
REQ-020 out_ready bits of non-selected channels SHALL be ignored.
REQ-021 in_valid and D SHALL be ignored while in WAIT; the source holds them until in_ready=1.
REQ-022 The wait counter SHALL be 8 bits, increment each WAIT cycle with out_ready[S]=0, and clear on transfer or skip.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL go to IDLE with S=0, hold=0, wait counter=0, Y=4'b0000, out_valid=4'b0000, skip=0; in_ready is therefore 1 in the following cycle.
REQ-024 Reset asserted during WAIT SHALL discard the held bit without delivering it; rst SHALL take priority over every other event in the same cycle.

Configuration
REQ-025 With macro DEMUX_TIMEOUT_EN defined, in WAIT when out_ready[S]=0 and the wait counter equals TIMEOUT-1, the block SHALL on the next edge increment S modulo 4, clear the counter, stay in WAIT retaining hold, and pulse skip for one cycle.
REQ-026 With DEMUX_TIMEOUT_EN defined, when out_ready[S]=1 in the same cycle the counter reaches TIMEOUT-1, the transfer SHALL win and no skip is produced.
REQ-027 With DEMUX_TIMEOUT_EN undefined, the block SHALL wait on the selected channel indefinitely (strict round-robin), skip SHALL be tied to 0, and the wait counter logic SHALL be absent.

Verification
REQ-028 Reset, then D=1,0,1,1 each with in_valid and out_ready=4'b1111 -> bits appear on Y[0],Y[1],Y[2],Y[3] in order, out_valid=0001,0010,0100,1000, and S returns to 0.
REQ-029 rst=1 for one cycle while in WAIT with hold=1 on S=2 -> next cycle S=0, out_valid=0000, Y=0000, in_ready=1.
REQ-030 DEMUX_TIMEOUT_EN defined, TIMEOUT=8, D=1 accepted with out_ready=4'b1110 -> 8 WAIT cycles on channel 0, skip pulses once, then S=1, Y[1]=1, out_valid=0010 delivered.
REQ-031 DEMUX_TIMEOUT_EN defined, out_ready[S] rises on exactly the 8th WAIT cycle -> transfer on channel S, skip stays 0.
REQ-032 DEMUX_TIMEOUT_EN undefined, out_ready=4'b0000 for 300 cycles then 4'b0001 -> S stays 0 throughout, skip=0, bit delivered on Y[0].
REQ-033 in_valid held at 1 with D toggling while in WAIT -> the held bit is unchanged and in_ready=0.
